// File: rtl/ct_sysio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ct_sysio_pkg
// Purpose  : Shared definitions for the sysio L2C flush control slice:
//            one-hot flush FSM state encoding, completed-flush counter width
//            and the default hang-timeout length.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ct_sysio_pkg;

  // Width of the completed-flush counter (wraps modulo 2^W).
  localparam int CT_SYSIO_FLUSH_CNT_W = 8;

  // Default timeout counter width and length in sysio_clk cycles spent in REQ.
  localparam int          CT_SYSIO_FLUSH_TMO_W   = 16;
  localparam int unsigned CT_SYSIO_FLUSH_TMO_CYC = 32'h0000_FFFF;

  // One-hot flush FSM encoding.
  typedef enum logic [3:0] {
    FLUSH_IDLE = 4'b0001,
    FLUSH_REQ  = 4'b0010,
    FLUSH_DONE = 4'b0100,
    FLUSH_ERR  = 4'b1000
  } flush_state_e;

endpackage : ct_sysio_pkg
`default_nettype wire

// File: rtl/ct_sysio_flush_timer.sv
`default_nettype none
// ============================================================================
// Module   : ct_sysio_flush_timer
// Purpose  : Hang timer for an outstanding L2C flush request.
// Ports    : sysio_clk / cpurst_b - clock, async active-low reset
//            clear  - zero the timer (flush request being issued)
//            enable - timer armed (flush request outstanding)
//            count  - advance qualifier; low once L2C reports done, so a
//                     done arriving on the last cycle always beats expiry
//            expire - combinational: this is the last allowed cycle and
//                     the timer is still advancing
// Revision : 1.0 - initial release
// ============================================================================
module ct_sysio_flush_timer
  import ct_sysio_pkg::*;
#(
  parameter int          TMO_W   = CT_SYSIO_FLUSH_TMO_W,
  parameter int unsigned TMO_CYC = CT_SYSIO_FLUSH_TMO_CYC
) (
  input  logic sysio_clk,
  input  logic cpurst_b,
  input  logic clear,
  input  logic enable,
  input  logic count,
  output logic expire
);

  // Last cycle index that is still allowed in REQ.
  localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TMO_CYC - 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             w_advance;

  assign w_advance = enable & count;

  always_ff @(posedge sysio_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_tmo_cnt <= '0;
    end else if (clear) begin
      r_tmo_cnt <= '0;
    end else if (w_advance) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  assign expire = w_advance & (r_tmo_cnt == c_tmo_last);

endmodule : ct_sysio_flush_timer
`default_nettype wire

// File: rtl/ct_sysio_l2c_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ct_sysio_l2c_flush_ctrl
// Purpose  : Turns the level L2-flush request from the sysio pad side into a
//            4-phase request/done handshake with L2C. Entry is gated on L2C
//            idle and qualified by the AXI-master clock-ratio strobe; done is
//            held until the pad side drops its request on a strobe. Counts
//            completed flushes. Optional hang timeout enabled by the macro
//            CT_SYSIO_L2C_FLUSH_TIMEOUT_EN (default build: no timer,
//            flush_err tied low, ERR unreachable).
// Ports    : sysio_clk, cpurst_b    - clock, async active-low reset
//            axim_clk_en            - pad-side sampling strobe
//            sysio_l2c_flush_req    - level flush request from sysio
//            l2c_sysio_flush_idle   - L2C has no flush in progress
//            l2c_sysio_flush_done   - L2C flush complete (pulse or level)
//            flush_l2c_req          - flush request to L2C
//            flush_sysio_done       - handshake done back to sysio
//            flush_busy             - FSM not in IDLE
//            flush_err              - sticky timeout flag
//            flush_cnt              - completed flushes (normal or timed out)
// Revision : 1.0 - initial release
// ============================================================================
module ct_sysio_l2c_flush_ctrl
  import ct_sysio_pkg::*;
#(
  parameter int          CNT_W   = CT_SYSIO_FLUSH_CNT_W,
  parameter int          TMO_W   = CT_SYSIO_FLUSH_TMO_W,
  parameter int unsigned TMO_CYC = CT_SYSIO_FLUSH_TMO_CYC
) (
  input  logic             sysio_clk,
  input  logic             cpurst_b,
  input  logic             axim_clk_en,
  input  logic             sysio_l2c_flush_req,
  input  logic             l2c_sysio_flush_idle,
  input  logic             l2c_sysio_flush_done,
  output logic             flush_l2c_req,
  output logic             flush_sysio_done,
  output logic             flush_busy,
  output logic             flush_err,
  output logic [CNT_W-1:0] flush_cnt
);

  // Reject configurations the timer cannot honour.
  if ((TMO_CYC < 2) || (TMO_W < 1)) begin : g_bad_tmo_cfg
    $error("ct_sysio_l2c_flush_ctrl: TMO_CYC must be >= 2 and TMO_W >= 1");
  end

  flush_state_e r_state;
  logic         w_start;
  logic         w_release;
  logic         w_tmo_expire;

  // Launch only on a strobe, with a request pending and L2C idle.
  assign w_start   = axim_clk_en & sysio_l2c_flush_req & l2c_sysio_flush_idle;
  // Leave DONE/ERR only once the pad side has dropped its request on a strobe,
  // so done stays visible for at least one strobe period.
  assign w_release = axim_clk_en & ~sysio_l2c_flush_req;

`ifdef CT_SYSIO_L2C_FLUSH_TIMEOUT_EN
  logic r_flush_err;

  ct_sysio_flush_timer #(
    .TMO_W   (TMO_W),
    .TMO_CYC (TMO_CYC)
  ) u_flush_timer (
    .sysio_clk (sysio_clk),
    .cpurst_b  (cpurst_b),
    .clear     ((r_state == FLUSH_IDLE) & w_start),
    .enable    (r_state == FLUSH_REQ),
    .count     (~l2c_sysio_flush_done),
    .expire    (w_tmo_expire)
  );

  assign flush_err = r_flush_err;
`else
  assign w_tmo_expire = 1'b0;
  assign flush_err    = 1'b0;
`endif

  always_ff @(posedge sysio_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state          <= FLUSH_IDLE;
      flush_l2c_req    <= 1'b0;
      flush_sysio_done <= 1'b0;
      flush_busy       <= 1'b0;
      flush_cnt        <= '0;
`ifdef CT_SYSIO_L2C_FLUSH_TIMEOUT_EN
      r_flush_err      <= 1'b0;
`endif
    end else begin
      case (r_state)
        FLUSH_IDLE: begin
          // L2C done is deliberately ignored here.
          if (w_start) begin
            r_state       <= FLUSH_REQ;
            flush_l2c_req <= 1'b1;
            flush_busy    <= 1'b1;
`ifdef CT_SYSIO_L2C_FLUSH_TIMEOUT_EN
            r_flush_err   <= 1'b0;
`endif
          end
        end

        FLUSH_REQ: begin
          // Done is sampled every cycle (not strobe-qualified) and has
          // priority over a simultaneous timeout.
          if (l2c_sysio_flush_done) begin
            r_state          <= FLUSH_DONE;
            flush_l2c_req    <= 1'b0;
            flush_sysio_done <= 1'b1;
            flush_cnt        <= flush_cnt + CNT_W'(1);
          end else if (w_tmo_expire) begin
            r_state          <= FLUSH_ERR;
            flush_l2c_req    <= 1'b0;
            flush_sysio_done <= 1'b1;
            flush_cnt        <= flush_cnt + CNT_W'(1);
`ifdef CT_SYSIO_L2C_FLUSH_TIMEOUT_EN
            r_flush_err      <= 1'b1;
`endif
          end
        end

        FLUSH_DONE, FLUSH_ERR: begin
          // flush_err is left as-is: it is sticky until the next REQ entry.
          if (w_release) begin
            r_state          <= FLUSH_IDLE;
            flush_sysio_done <= 1'b0;
            flush_busy       <= 1'b0;
          end
        end

        default: begin
          // Illegal one-hot code: recover to IDLE without reporting done.
          r_state          <= FLUSH_IDLE;
          flush_l2c_req    <= 1'b0;
          flush_sysio_done <= 1'b0;
          flush_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule : ct_sysio_l2c_flush_ctrl
`default_nettype wire

// File: tb/tb_ct_sysio_l2c_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ct_sysio_l2c_flush_ctrl
// Purpose  : Self-checking bench for ct_sysio_l2c_flush_ctrl: a table of
//            per-cycle directed vectors followed by hand-written multi-cycle
//            sequences (strobed flush, idle gating, request drop, wrap,
//            no re-flush, timeout when CT_SYSIO_L2C_FLUSH_TIMEOUT_EN is set,
//            asynchronous reset mid-REQ).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ct_sysio_l2c_flush_ctrl;

  logic       sysio_clk = 1'b0;
  logic       cpurst_b;
  logic       axim_clk_en;
  logic       sysio_l2c_flush_req;
  logic       l2c_sysio_flush_idle;
  logic       l2c_sysio_flush_done;
  logic       flush_l2c_req;
  logic       flush_sysio_done;
  logic       flush_busy;
  logic       flush_err;
  logic [7:0] flush_cnt;

  int errs   = 0;
  int checks = 0;
  logic [7:0] exp_cnt;

  ct_sysio_l2c_flush_ctrl #(
    .CNT_W   (8),
    .TMO_W   (16),
    .TMO_CYC (16)
  ) dut (
    .sysio_clk            (sysio_clk),
    .cpurst_b             (cpurst_b),
    .axim_clk_en          (axim_clk_en),
    .sysio_l2c_flush_req  (sysio_l2c_flush_req),
    .l2c_sysio_flush_idle (l2c_sysio_flush_idle),
    .l2c_sysio_flush_done (l2c_sysio_flush_done),
    .flush_l2c_req        (flush_l2c_req),
    .flush_sysio_done     (flush_sysio_done),
    .flush_busy           (flush_busy),
    .flush_err            (flush_err),
    .flush_cnt            (flush_cnt)
  );

  always #5 sysio_clk = ~sysio_clk;

  typedef struct packed {
    logic       en;
    logic       req;
    logic       idle;
    logic       done;
    logic       x_l2c;
    logic       x_sd;
    logic       x_busy;
    logic [7:0] x_cnt;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 ns after the active edge.
  task automatic tick();
    @(posedge sysio_clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic req, input logic idle, input logic done);
    axim_clk_en          = en;
    sysio_l2c_flush_req  = req;
    l2c_sysio_flush_idle = idle;
    l2c_sysio_flush_done = done;
  endtask

  // Minimal complete flush with a strobe every cycle; ends back in IDLE.
  task automatic flush_fast();
    drive(1, 1, 1, 0); tick();
    drive(1, 1, 1, 1); tick();
    drive(1, 0, 1, 0); tick();
    exp_cnt = exp_cnt + 8'd1;
  endtask

  initial begin
    int hi;
    int bad;

    //         en req idle done | l2c sd busy cnt
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}; // no strobe
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}; // L2C busy
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0}; // enter REQ, done ignored
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0}; // req drop: no abort
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1}; // done -> DONE
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1}; // hold until strobe
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1}; // back to IDLE
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2}; // req high: stay DONE
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2}; // no re-flush
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2}; // done ignored in IDLE

    // ---------------- reset ----------------
    cpurst_b = 1'b0;
    drive(0, 0, 1, 0);
    #3;
    chk("rst_l2c",  {31'd0, flush_l2c_req},    0);
    chk("rst_sd",   {31'd0, flush_sysio_done}, 0);
    chk("rst_busy", {31'd0, flush_busy},       0);
    chk("rst_err",  {31'd0, flush_err},        0);
    chk("rst_cnt",  {24'd0, flush_cnt},        0);
    #9 cpurst_b = 1'b1;
    exp_cnt = 8'd0;
    tick();

    // ---------------- vector table ----------------
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].en, tbl[i].req, tbl[i].idle, tbl[i].done);
      tick();
      chk($sformatf("vec%0d_l2c", i),  {31'd0, flush_l2c_req},    {31'd0, tbl[i].x_l2c});
      chk($sformatf("vec%0d_sd", i),   {31'd0, flush_sysio_done}, {31'd0, tbl[i].x_sd});
      chk($sformatf("vec%0d_busy", i), {31'd0, flush_busy},       {31'd0, tbl[i].x_busy});
      chk($sformatf("vec%0d_err", i),  {31'd0, flush_err},        0);
      chk($sformatf("vec%0d_cnt", i),  {24'd0, flush_cnt},        {24'd0, tbl[i].x_cnt});
    end
    exp_cnt = 8'd2;

    // ---------------- basic flush, strobe every 2nd cycle ----------------
    drive(1, 1, 1, 0); tick();
    chk("basic_req_rise", {31'd0, flush_l2c_req}, 1);
    hi = 1;
    for (int j = 0; j < 10; j++) begin
      drive(j[0] ? 1'b0 : 1'b1, 1'b1, 1'b1, (j == 9) ? 1'b1 : 1'b0);
      tick();
      if (flush_l2c_req) hi++;
    end
    exp_cnt = exp_cnt + 8'd1;
    chk("basic_req_cycles", hi, 10);
    chk("basic_sd_1cyc", {31'd0, flush_sysio_done}, 1);
    chk("basic_cnt", {24'd0, flush_cnt}, {24'd0, exp_cnt});
    drive(0, 0, 1, 0); tick();
    chk("basic_sd_hold_nostrobe", {31'd0, flush_sysio_done}, 1);
    drive(1, 0, 1, 0); tick();
    chk("basic_sd_clear", {31'd0, flush_sysio_done}, 0);
    chk("basic_busy_clear", {31'd0, flush_busy}, 0);

    // ---------------- idle gating ----------------
    bad = 0;
    for (int j = 0; j < 20; j++) begin
      drive(j[0] ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      if (flush_l2c_req || flush_busy) bad++;
    end
    chk("gate_hold", bad, 0);
    drive(0, 1, 1, 0); tick();
    chk("gate_nostrobe", {31'd0, flush_l2c_req}, 0);
    drive(1, 1, 1, 0); tick();
    chk("gate_first_strobe", {31'd0, flush_l2c_req}, 1);
    drive(1, 1, 1, 1); tick();
    drive(1, 0, 1, 0); tick();
    exp_cnt = exp_cnt + 8'd1;
    chk("gate_cnt", {24'd0, flush_cnt}, {24'd0, exp_cnt});

    // ---------------- request drop mid-flush ----------------
    drive(1, 1, 1, 0); tick();
    hi = flush_l2c_req ? 1 : 0;
    for (int j = 1; j <= 8; j++) begin
      drive(1'b0, (j < 3) ? 1'b1 : 1'b0, 1'b1, (j == 8) ? 1'b1 : 1'b0);
      tick();
      if (flush_l2c_req) hi++;
    end
    exp_cnt = exp_cnt + 8'd1;
    chk("drop_req_cycles", hi, 8);
    chk("drop_sd_rise", {31'd0, flush_sysio_done}, 1);
    drive(1, 0, 1, 0); tick();
    chk("drop_sd_clear", {31'd0, flush_sysio_done}, 0);
    chk("drop_cnt", {24'd0, flush_cnt}, {24'd0, exp_cnt});

    // ---------------- no automatic re-flush ----------------
    drive(1, 1, 1, 0); tick();
    drive(1, 1, 1, 1); tick();
    exp_cnt = exp_cnt + 8'd1;
    bad = 0;
    for (int j = 0; j < 12; j++) begin
      drive(1, 1, 1, 0); tick();
      if (flush_l2c_req || !flush_sysio_done) bad++;
    end
    chk("noreflush", bad, 0);
    drive(1, 0, 1, 0); tick();
    chk("noreflush_cnt", {24'd0, flush_cnt}, {24'd0, exp_cnt});

    // ---------------- counter wrap ----------------
    cpurst_b = 1'b0; #2; cpurst_b = 1'b1;
    exp_cnt = 8'd0;
    for (int j = 0; j < 255; j++) flush_fast();
    chk("wrap_255", {24'd0, flush_cnt}, 255);
    flush_fast();
    chk("wrap_256", {24'd0, flush_cnt}, 0);

`ifdef CT_SYSIO_L2C_FLUSH_TIMEOUT_EN
    // ---------------- timeout (TMO_CYC = 16) ----------------
    drive(1, 1, 1, 0); tick();
    hi = 1;
    for (int j = 0; j < 40; j++) begin
      tick();
      if (flush_l2c_req) hi++;
      else break;
    end
    exp_cnt = exp_cnt + 8'd1;
    chk("tmo_req_cycles", hi, 16);
    chk("tmo_sd", {31'd0, flush_sysio_done}, 1);
    chk("tmo_err", {31'd0, flush_err}, 1);
    chk("tmo_cnt", {24'd0, flush_cnt}, {24'd0, exp_cnt});
    drive(1, 0, 1, 0); tick();
    chk("tmo_err_sticky", {31'd0, flush_err}, 1);
    chk("tmo_idle_sd", {31'd0, flush_sysio_done}, 0);
    drive(1, 1, 1, 0); tick();
    chk("tmo_err_clear", {31'd0, flush_err}, 0);
    for (int j = 0; j < 15; j++) tick();
    chk("tmo_race_still_req", {31'd0, flush_l2c_req}, 1);
    drive(1, 1, 1, 1); tick();
    exp_cnt = exp_cnt + 8'd1;
    chk("tmo_race_sd", {31'd0, flush_sysio_done}, 1);
    chk("tmo_race_err", {31'd0, flush_err}, 0);
    drive(1, 0, 1, 0); tick();
    chk("tmo_race_cnt", {24'd0, flush_cnt}, {24'd0, exp_cnt});
`endif

    // ---------------- async reset mid-REQ ----------------
    flush_fast();
    drive(1, 1, 1, 0); tick();
    chk("arst_in_req", {31'd0, flush_l2c_req}, 1);
    #2 cpurst_b = 1'b0;
    #1;
    chk("arst_l2c",  {31'd0, flush_l2c_req},    0);
    chk("arst_sd",   {31'd0, flush_sysio_done}, 0);
    chk("arst_busy", {31'd0, flush_busy},       0);
    chk("arst_cnt",  {24'd0, flush_cnt},        0);
    drive(0, 0, 1, 0);
    @(negedge sysio_clk);
    cpurst_b = 1'b1;
    exp_cnt = 8'd0;
    tick();
    flush_fast();
    chk("arst_after_cnt", {24'd0, flush_cnt}, {24'd0, exp_cnt});
    chk("arst_after_busy", {31'd0, flush_busy}, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule : tb_ct_sysio_l2c_flush_ctrl
`default_nettype wire
